// File: rtl/ddr_rx_frame_tracker.sv
// HDR-DDR target receive framer: deserializes SDA on both SCL edges into
// preamble/data/parity words, tracks frame length and captures the CRC word.
module ddr_rx_frame_tracker #(
  parameter int          DATA_W    = 16,
  parameter int          CNT_W     = 16,
  parameter logic [3:0]  CRC_TOKEN = 4'hC
) (
  input  logic              i_frx_clk,
  input  logic              i_frx_rst,
  input  logic              i_frx_en,
  input  logic [CNT_W-1:0]  i_frx_exp_words,
  input  logic              i_scl_pos_edge,
  input  logic              i_scl_neg_edge,
  input  logic              i_sda,
  output logic [DATA_W-1:0] o_frx_data,
  output logic              o_frx_data_valid,
  output logic              o_frx_parity_err,
  output logic              o_frx_frame_err,
  output logic              o_frx_token_err,
  output logic              o_frx_last_frame,
  output logic [4:0]        o_frx_crc_value,
  output logic              o_frx_crc_valid,
  output logic              o_frx_done
);

  localparam int BIT_W = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    IDLE, PRE1, PRE0, DATA, PAR, CRC_TOK, CRC_VAL, DONE
  } state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   shift_reg;
  logic [BIT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    remaining;
  logic                pre_hi;
  logic                par_hi;
  logic                edge_seen;
  logic                pa1, pa0;

  assign edge_seen = i_scl_pos_edge | i_scl_neg_edge;

  always_comb begin
    pa1 = 1'b0;
    pa0 = 1'b1;
    for (int i = 0; i < DATA_W; i++) begin
      if ((i % 2) == 1) pa1 = pa1 ^ shift_reg[i];
      else              pa0 = pa0 ^ shift_reg[i];
    end
  end

  always_ff @(posedge i_frx_clk or posedge i_frx_rst) begin
    if (i_frx_rst) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_frx_en) state_next = PRE1;
      PRE1:    if (edge_seen) state_next = PRE0;
      PRE0: begin
        if (edge_seen) begin
          case ({pre_hi, i_sda})
            2'b11:   state_next = DATA;
            2'b01:   state_next = CRC_TOK;
            default: state_next = DONE;
          endcase
        end
      end
      DATA:    if (edge_seen && bit_cnt == '0) state_next = PAR;
      PAR:     if (edge_seen && bit_cnt == '0) state_next = PRE1;
      CRC_TOK: if (edge_seen && bit_cnt == '0) state_next = CRC_VAL;
      CRC_VAL: if (edge_seen && bit_cnt == '0) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (!i_frx_en) state_next = IDLE;
  end

  // Datapath, sticky flags and registered output pulses; all sampling is
  // gated by the current state so IDLE and DONE never consume bits.
  always_ff @(posedge i_frx_clk or posedge i_frx_rst) begin
    if (i_frx_rst) begin
      shift_reg        <= '0;
      bit_cnt          <= '0;
      remaining        <= '0;
      pre_hi           <= 1'b0;
      par_hi           <= 1'b0;
      o_frx_data       <= '0;
      o_frx_data_valid <= 1'b0;
      o_frx_parity_err <= 1'b0;
      o_frx_frame_err  <= 1'b0;
      o_frx_token_err  <= 1'b0;
      o_frx_last_frame <= 1'b0;
      o_frx_crc_value  <= '0;
      o_frx_crc_valid  <= 1'b0;
      o_frx_done       <= 1'b0;
    end else if (!i_frx_en) begin
      remaining        <= i_frx_exp_words;
      shift_reg        <= '0;
      bit_cnt          <= '0;
      o_frx_data_valid <= 1'b0;
      o_frx_crc_valid  <= 1'b0;
      o_frx_parity_err <= 1'b0;
      o_frx_frame_err  <= 1'b0;
      o_frx_token_err  <= 1'b0;
      o_frx_last_frame <= 1'b0;
      o_frx_done       <= 1'b0;
    end else begin
      o_frx_data_valid <= 1'b0;
      o_frx_crc_valid  <= 1'b0;
      if (state == IDLE && remaining == '0) o_frx_last_frame <= 1'b1;
      if (edge_seen) begin
        case (state)
          PRE1: pre_hi <= i_sda;
          PRE0: begin
            case ({pre_hi, i_sda})
              2'b11: bit_cnt <= BIT_W'(DATA_W - 1);
              2'b01: begin
                bit_cnt <= BIT_W'(3);
                if (remaining != '0) o_frx_frame_err <= 1'b1;
              end
              default: begin
                o_frx_frame_err <= 1'b1;
                o_frx_done      <= 1'b1;
              end
            endcase
          end
          DATA: begin
            shift_reg <= {shift_reg[DATA_W-2:0], i_sda};
            if (bit_cnt == '0) bit_cnt <= BIT_W'(1);
            else               bit_cnt <= bit_cnt - 1'b1;
          end
          PAR: begin
            if (bit_cnt != '0) begin
              par_hi  <= i_sda;
              bit_cnt <= bit_cnt - 1'b1;
            end else begin
              if ({par_hi, i_sda} != {pa1, pa0}) o_frx_parity_err <= 1'b1;
              o_frx_data       <= shift_reg;
              o_frx_data_valid <= 1'b1;
              // An extra word is still delivered but flagged; the counter saturates at 0.
              if (remaining == '0) begin
                o_frx_frame_err <= 1'b1;
              end else begin
                remaining <= remaining - 1'b1;
                if (remaining == CNT_W'(1)) o_frx_last_frame <= 1'b1;
              end
            end
          end
          CRC_TOK: begin
            shift_reg <= {shift_reg[DATA_W-2:0], i_sda};
            if (bit_cnt == '0) begin
              if ({shift_reg[2:0], i_sda} != CRC_TOKEN) o_frx_token_err <= 1'b1;
              bit_cnt <= BIT_W'(4);
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          CRC_VAL: begin
            shift_reg <= {shift_reg[DATA_W-2:0], i_sda};
            if (bit_cnt == '0) begin
              o_frx_crc_value <= {shift_reg[3:0], i_sda};
              o_frx_crc_valid <= 1'b1;
              o_frx_done      <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_rx_frame_tracker.sv
// Directed self-checking bench for ddr_rx_frame_tracker: hand-built DDR words
// and CRC words with hand-computed parity and expected flag values.
module tb_ddr_rx_frame_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] expWords = '0;
  logic        sclPos = 1'b0;
  logic        sclNeg = 1'b0;
  logic        sda = 1'b0;
  logic [15:0] data;
  logic        dataValid;
  logic        parityErr;
  logic        frameErr;
  logic        tokenErr;
  logic        lastFrame;
  logic [4:0]  crcValue;
  logic        crcValid;
  logic        done;

  int cmpCount = 0;
  int errCount = 0;
  int dvCount = 0;
  int crcCount = 0;
  logic [15:0] lastData = '0;
  logic        lastFrameAtDv = 1'b0;
  logic        edgePhase = 1'b0;
  int dvBase;
  int crcBase;

  ddr_rx_frame_tracker dut (
    .i_frx_clk        (clk),
    .i_frx_rst        (rst),
    .i_frx_en         (en),
    .i_frx_exp_words  (expWords),
    .i_scl_pos_edge   (sclPos),
    .i_scl_neg_edge   (sclNeg),
    .i_sda            (sda),
    .o_frx_data       (data),
    .o_frx_data_valid (dataValid),
    .o_frx_parity_err (parityErr),
    .o_frx_frame_err  (frameErr),
    .o_frx_token_err  (tokenErr),
    .o_frx_last_frame (lastFrame),
    .o_frx_crc_value  (crcValue),
    .o_frx_crc_valid  (crcValid),
    .o_frx_done       (done)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts delivered words and CRC captures between checks.
  always @(negedge clk) begin
    if (dataValid) begin
      dvCount       <= dvCount + 1;
      lastData      <= data;
      lastFrameAtDv <= lastFrame;
    end
    if (crcValid) crcCount <= crcCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    cmpCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic b, input logic both);
    @(negedge clk);
    sda = b;
    if (both) begin
      sclPos = 1'b1;
      sclNeg = 1'b1;
    end else begin
      sclPos = ~edgePhase;
      sclNeg = edgePhase;
      edgePhase = ~edgePhase;
    end
    @(negedge clk);
    sclPos = 1'b0;
    sclNeg = 1'b0;
  endtask

  task automatic sendBits(input logic [31:0] value, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(value[i], 1'b0);
  endtask

  task automatic sendWord(input logic [15:0] w, input logic [1:0] par);
    sendBits(32'(2'b11), 2);
    sendBits(32'(w), 16);
    sendBits(32'(par), 2);
  endtask

  task automatic sendCrc(input logic [3:0] tok, input logic [4:0] crc);
    sendBits(32'(2'b01), 2);
    sendBits(32'(tok), 4);
    sendBits(32'(crc), 5);
  endtask

  task automatic startFrame(input logic [15:0] exp);
    @(negedge clk);
    en = 1'b0;
    expWords = exp;
    repeat (2) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    dvBase = dvCount;
    crcBase = crcCount;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_data", 32'(data), 32'h0);
    checkOutput("reset_flags", 32'({dataValid, parityErr, frameErr, tokenErr, lastFrame, crcValid, done}), 32'h0);
    checkOutput("reset_crc", 32'(crcValue), 32'h0);
    rst = 1'b0;

    // Nominal single-word frame with CRC.
    startFrame(16'd1);
    sendWord(16'hA5A5, 2'b01);
    sendCrc(4'hC, 5'h13);
    repeat (3) @(negedge clk);
    checkOutput("s1_dv_count", 32'(dvCount - dvBase), 32'd1);
    checkOutput("s1_data", 32'(lastData), 32'hA5A5);
    checkOutput("s1_last_at_dv", 32'(lastFrameAtDv), 32'd1);
    checkOutput("s1_crc_count", 32'(crcCount - crcBase), 32'd1);
    checkOutput("s1_crc_value", 32'(crcValue), 32'h13);
    checkOutput("s1_done", 32'(done), 32'd1);
    checkOutput("s1_errs", 32'({parityErr, frameErr, tokenErr}), 32'h0);

    // Bad parity on an otherwise good word.
    startFrame(16'd1);
    sendWord(16'hA5A5, 2'b11);
    repeat (3) @(negedge clk);
    checkOutput("s2_dv_count", 32'(dvCount - dvBase), 32'd1);
    checkOutput("s2_data", 32'(lastData), 32'hA5A5);
    checkOutput("s2_errs", 32'({parityErr, frameErr, tokenErr}), 32'b100);
    checkOutput("s2_last", 32'(lastFrame), 32'd1);

    // Short frame: CRC arrives with one word still expected.
    startFrame(16'd2);
    checkOutput("s3_sticky_cleared", 32'(parityErr), 32'd0);
    sendWord(16'hA5A5, 2'b01);
    sendCrc(4'hC, 5'h0A);
    repeat (3) @(negedge clk);
    checkOutput("s3_frame_err", 32'(frameErr), 32'd1);
    checkOutput("s3_last", 32'(lastFrame), 32'd0);
    checkOutput("s3_crc_count", 32'(crcCount - crcBase), 32'd1);
    checkOutput("s3_crc_value", 32'(crcValue), 32'h0A);
    checkOutput("s3_done", 32'(done), 32'd1);

    // Extra word beyond the expected length.
    startFrame(16'd1);
    sendWord(16'hA5A5, 2'b01);
    @(negedge clk);
    checkOutput("s4_no_err_first", 32'(frameErr), 32'd0);
    sendWord(16'h00FF, 2'b01);
    repeat (3) @(negedge clk);
    checkOutput("s4_dv_count", 32'(dvCount - dvBase), 32'd2);
    checkOutput("s4_data", 32'(lastData), 32'h00FF);
    checkOutput("s4_errs", 32'({parityErr, frameErr, tokenErr}), 32'b010);

    // Zero-length frame, then an illegal preamble 10.
    startFrame(16'd0);
    @(negedge clk);
    checkOutput("s5_last_zero", 32'(lastFrame), 32'd1);
    sendBits(32'(2'b10), 2);
    @(negedge clk);
    checkOutput("s5_frame_err", 32'(frameErr), 32'd1);
    checkOutput("s5_done", 32'(done), 32'd1);
    sendBits(32'hFFFFF, 20);
    repeat (3) @(negedge clk);
    checkOutput("s5_no_dv", 32'(dvCount - dvBase), 32'd0);
    checkOutput("s5_still_done", 32'(done), 32'd1);

    // Reset in the middle of a data word, then a clean word with one double edge.
    startFrame(16'd1);
    sendBits(32'(2'b11), 2);
    sendBits(32'h7F, 7);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    checkOutput("s6_rst_data", 32'(data), 32'h0);
    checkOutput("s6_rst_flags", 32'({dataValid, parityErr, frameErr, tokenErr, lastFrame, crcValid, done}), 32'h0);
    rst = 1'b0;
    startFrame(16'd1);
    sendBits(32'(2'b11), 2);
    sendBits(32'(6'h0F), 6);
    applyStimulus(1'b0, 1'b1);
    sendBits(32'(9'h05A), 9);
    sendBits(32'(2'b01), 2);
    repeat (3) @(negedge clk);
    checkOutput("s6_dv_count", 32'(dvCount - dvBase), 32'd1);
    checkOutput("s6_data", 32'(lastData), 32'h3C5A);
    checkOutput("s6_errs", 32'({parityErr, frameErr, tokenErr}), 32'h0);
    checkOutput("s6_last", 32'(lastFrame), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ddr_rx_frame_tracker.md
Name: ddr_rx_frame_tracker

Overview:
Target-side HDR-DDR receive framer. It is the receiving end of the controller-side CCC frame counter.
- Deserializes controller-driven SDA on both SCL edges into 20-bit DDR data words (2 preamble, 16 data, 2 parity).
- Checks parity, counts received words against the expected frame count and flags the last frame.
- Captures the terminating CRC word (token + CRC5) for the downstream CRC checker.
- Sits between the target SDA/SCL edge detectors and the target CCC/data handler.

Parameters:
DATA_W, 16, data payload bits per DDR word
CNT_W, 16, width of the frame counter and expected-length input
CRC_TOKEN, 4'hC, required token value in the CRC word

Ports:
i_frx_clk  input  1  system clock
i_frx_rst  input  1  asynchronous active-high reset
i_frx_en  input  1  1 = receive active; 0 = idle, loads expected count
i_frx_exp_words  input  CNT_W  expected data words in the frame; sampled while en=0
i_scl_pos_edge  input  1  single-cycle strobe, SCL rising edge
i_scl_neg_edge  input  1  single-cycle strobe, SCL falling edge
i_sda  input  1  synchronized SDA
o_frx_data  output  DATA_W  last received data word
o_frx_data_valid  output  1  1-cycle pulse, o_frx_data updated
o_frx_parity_err  output  1  sticky: parity mismatch on any word
o_frx_frame_err  output  1  sticky: illegal preamble or length mismatch
o_frx_token_err  output  1  sticky: CRC token != CRC_TOKEN
o_frx_last_frame  output  1  level: word count reached expected
o_frx_crc_value  output  5  captured CRC5
o_frx_crc_valid  output  1  1-cycle pulse, CRC word fully received
o_frx_done  output  1  level: frame finished (CRC received or error)

Behaviour:
- Reset (async, rst=1):
  - State IDLE. All outputs 0. Counter 0. Shift register 0.
- Bit sampling:
  - An "edge" is a cycle with pos_edge | neg_edge; both high in the same cycle counts as one edge.
  - SDA is sampled MSB first on each edge. No sampling in IDLE or DONE.
- en=0:
  - Go to IDLE from any state; clear sticky errors, last_frame and done.
  - remaining <= exp_words.
  - If exp_words = 0, last_frame = 1 immediately on entering PREAMBLE.
- FSM states: IDLE, PRE1, PRE0, DATA, PAR, CRC_TOK, CRC_VAL, DONE.
  - IDLE -> PRE1 on the first cycle with en=1.
  - PRE1: sample p1 -> PRE0.
  - PRE0: sample p0.
    - {p1,p0} = 11 -> DATA (bit counter = 15).
    - 01 -> CRC_TOK (bit counter = 3).
    - 00 or 10 -> frame_err=1, done=1, DONE.
  - DATA: shift 16 bits -> PAR.
  - PAR: sample 2 bits and compare with the computed parity:
    - PA1 = XOR of D[15],D[13],...,D[1].
    - PA0 = XOR of D[14],D[12],...,D[0], XOR 1.
    - Mismatch sets parity_err; the word is still delivered.
- Data word delivery (cycle after the second parity edge):
  - o_frx_data <= word; data_valid pulses 1 cycle.
  - If remaining = 0 before this word: frame_err=1 (extra word); word still delivered.
  - Otherwise remaining decrements; if it reaches 0, last_frame = 1 (same cycle as data_valid) and holds until en=0.
  - Next state PRE1.
- CRC word:
  - CRC_TOK: shift 4 bits. If value != CRC_TOKEN, set token_err.
  - CRC_VAL: shift 5 bits.
  - On the cycle after the 5th edge: crc_value loaded, crc_valid pulses, done=1, -> DONE.
  - If CRC preamble arrives while remaining != 0: frame_err=1 (short frame); CRC is still captured.
- DONE: ignore edges; hold outputs until en=0.
- Counter arithmetic: unsigned CNT_W bits, never wraps. Decrement is blocked at 0; an extra word raises frame_err instead.
- Reset mid-frame: immediate return to reset values; partially shifted word discarded.

Test Plan:
- exp_words=1; send preamble 11, data 0xA5A5, parity 01, then CRC preamble 01, token 1100, CRC 5'h13 -> data_valid once with data=0xA5A5 and parity_err=0; last_frame=1 same cycle; crc_valid pulses with crc_value=5'h13; done=1; no errors.
- exp_words=1; data 0xA5A5 with parity 11 -> data delivered, parity_err=1, others 0.
- exp_words=2; one data word then CRC -> frame_err=1, last_frame=0, crc_valid pulses, done=1.
- exp_words=1; two data words -> second data_valid pulses, frame_err=1.
- Preamble 10 -> frame_err=1 and done=1 after second edge; no data_valid; further edges ignored.
- Assert rst mid-DATA (after 7 data bits), release, en cycled -> all outputs 0; next full word received correctly. Also pos_edge and neg_edge high in the same cycle -> exactly one bit consumed.
